// File: rtl/fft_arb_pkg.sv
// Shared definitions for the symbol-granular FFT engine arbiter:
// state encoding, statistics width and a constant clog2 helper.
package fft_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int STAT_WIDTH = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_arb_tag_fifo.sv
// Synchronous tag FIFO recording which channel owns each symbol in flight.
// DEPTH must be a power of two (>= 2); simultaneous push/pop keeps occupancy.
module fft_arb_tag_fifo
  import fft_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == (AW+1)'(0));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= (AW+1)'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_comb begin
    if (empty) dout = WIDTH'(0);
    else       dout = mem[rd_ptr];
  end

endmodule

// File: rtl/fft_sym_arbiter.sv
// Round-robin, symbol-granular sharing of one FFT engine among NUM_CH streams.
// Optional statistics are built only when FFT_ARB_STAT_EN is defined.
module fft_sym_arbiter
  import fft_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 2,
  parameter int FFT_SIZE   = 4096,
  parameter int INDX_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              s_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_real,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_imag,
  output logic [NUM_CH-1:0]              s_ready,
  output logic                           fft_din_valid,
  output logic                           fft_din_sop,
  output logic                           fft_din_eop,
  output logic [DATA_WIDTH-1:0]          fft_din_real,
  output logic [DATA_WIDTH-1:0]          fft_din_imag,
  input  logic                           fft_din_ready,
  input  logic                           fft_dout_valid,
  input  logic                           fft_dout_eop,
  input  logic                           fft_dout_ready,
  output logic [CH_WIDTH-1:0]            out_ch,
  output logic                           out_ch_valid,
  output logic                           busy,
  output logic [NUM_CH*STAT_WIDTH-1:0]   stat_sym_cnt,
  output logic                           stat_orphan
);

  localparam logic [INDX_WIDTH-1:0] LAST_IDX = INDX_WIDTH'(FFT_SIZE - 1);

  logic [0:0]            state;
  logic [CH_WIDTH-1:0]   grant;
  logic [CH_WIDTH-1:0]   last_grant;
  logic [INDX_WIDTH-1:0] idx;
  logic [CH_WIDTH-1:0]   cand;
  logic [CH_WIDTH-1:0]   pick;
  logic                  found;
  logic                  xfer;
  logic                  sel_valid;
  logic                  beat;
  logic                  last_beat;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] ch_real [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_imag [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_real[k] = s_real[k*DATA_WIDTH +: DATA_WIDTH];
    assign ch_imag[k] = s_imag[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign xfer      = (state == ST_XFER);
  assign sel_valid = s_valid[grant];
  assign beat      = xfer & sel_valid & fft_din_ready;
  assign last_beat = beat & (idx == LAST_IDX);
  assign push      = ~xfer & found & ~fifo_full;
  assign pop       = fft_dout_valid & fft_dout_ready & fft_dout_eop;
  assign busy      = xfer;

  // Walk downward from the farthest offset so the nearest requester after last_grant wins.
  always_comb begin
    found = 1'b0;
    pick  = CH_WIDTH'(0);
    cand  = CH_WIDTH'(0);
    for (int i = NUM_CH; i >= 1; i--) begin
      cand  = CH_WIDTH'((int'(last_grant) + i) % NUM_CH);
      pick  = s_valid[cand] ? cand : pick;
      found = found | s_valid[cand];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= CH_WIDTH'(0);
      last_grant <= CH_WIDTH'(NUM_CH - 1);
      idx        <= INDX_WIDTH'(0);
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (last_beat) begin
            idx   <= INDX_WIDTH'(0);
            state <= ST_IDLE;
          end else if (beat) begin
            idx <= idx + INDX_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready       = NUM_CH'(0);
    fft_din_valid = 1'b0;
    fft_din_sop   = 1'b0;
    fft_din_eop   = 1'b0;
    fft_din_real  = DATA_WIDTH'(0);
    fft_din_imag  = DATA_WIDTH'(0);
    if (xfer) begin
      s_ready[grant] = fft_din_ready;
      fft_din_valid  = sel_valid;
      fft_din_sop    = beat & (idx == INDX_WIDTH'(0));
      fft_din_eop    = last_beat;
      fft_din_real   = ch_real[grant];
      fft_din_imag   = ch_imag[grant];
    end else begin
      fft_din_valid  = 1'b0;
    end
  end

  fft_arb_tag_fifo #(
    .WIDTH (CH_WIDTH),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (pick),
    .pop   (pop),
    .dout  (out_ch),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_ch_valid = ~fifo_empty;

`ifdef FFT_ARB_STAT_EN
  logic [STAT_WIDTH-1:0] sym_cnt [NUM_CH];
  logic                  orphan;

  // Orphan marks an engine output symbol that arrived with no tag queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) sym_cnt[k] <= STAT_WIDTH'(0);
      orphan <= 1'b0;
    end else begin
      if (last_beat) sym_cnt[grant] <= sym_cnt[grant] + STAT_WIDTH'(1);
      if (pop & fifo_empty) orphan <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    assign stat_sym_cnt[k*STAT_WIDTH +: STAT_WIDTH] = sym_cnt[k];
  end
  assign stat_orphan = orphan;
`else
  assign stat_sym_cnt = (NUM_CH*STAT_WIDTH)'(0);
  assign stat_orphan  = 1'b0;
`endif

endmodule
